// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller beside the ID/EX boundary. Compares decode-stage
//   register indices against a load in EX, watches branch resolution in EX, and
//   holds the front of the pipe while a multi-cycle mult/div op runs.
//   Control outputs are combinational, so they act in the same cycle. The FSM
//   state, the MDU countdown and the statistics counters are registered.
//
// Parameters
//   MDU_LAT   total MDU latency in cycles, issue cycle included (2..255)
//   CNT_W     width of the saturating statistics counters
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   id_rs, id_rt             source register indices of the ID instruction
//   id_uses_rs, id_uses_rt   ID instruction actually reads rs / rt
//   id_mdu_start             ID instruction issues a mult/div
//   ex_mem_read, ex_rt       EX instruction is a load, and its destination
//   ex_branch_taken          branch/jump resolved taken in EX
//   pc_stall, ifid_stall     hold the PC / the if_id register
//   ifid_flush               clear if_id to a nop
//   idex_nop                 insert a bubble into id_ex
//   mdu_busy                 MDU op in flight (state MDU_BUSY)
//   stall_cycles             saturating count of cycles with pc_stall=1
//   flush_count              saturating count of cycles with ifid_flush=1
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_mdu_start,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_nop,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] MDU_RELOAD = 8'(MDU_LAT - 2);

  state_t           state_q, state_d;
  logic [7:0]       mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             lu_hit;

  // Register $0 is hard-wired to zero, so a load targeting it never creates
  // a real dependency.
  assign lu_hit = ex_mem_read && (ex_rt != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_rt)) ||
                   (id_uses_rt && (id_rt == ex_rt)));

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    mdu_cnt_d  = mdu_cnt_q;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_nop   = 1'b0;
    mdu_busy   = 1'b0;

    if (rst_n) begin
      mdu_busy = (state_q == MDU_BUSY);

      // An MDU op in flight keeps counting down regardless of what the rest
      // of the pipe does; a branch only changes the front-end controls.
      if (state_q == MDU_BUSY) begin
        if (mdu_cnt_q == 8'd0) state_d = RUN;
        else                   mdu_cnt_d = mdu_cnt_q - 8'd1;
      end

      if (ex_branch_taken) begin
        // Taken branch wins: squash the wrong-path instructions in IF and ID.
        ifid_flush = 1'b1;
        idex_nop   = 1'b1;
      end else if (state_q == MDU_BUSY) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_nop   = 1'b1;
      end else if (lu_hit) begin
        // One bubble is enough: next cycle the load has moved on to MEM.
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_nop   = 1'b1;
      end else if (id_mdu_start) begin
        // The issue cycle itself flows through; the remaining MDU_LAT-1
        // cycles are spent in MDU_BUSY.
        state_d   = MDU_BUSY;
        mdu_cnt_d = MDU_RELOAD;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      mdu_cnt_q <= 8'd0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
      if (pc_stall && (stall_q != '1))   stall_q <= stall_q + 1'b1;
      if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule
